clkgen_multi: RTL and testbench

//   Synthesizable, parametrised successor to the testbench clock generator.

---
 rtl/clkgen_pkg.sv | 20 ++
 rtl/clkgen_if.sv | 29 ++
 rtl/clkgen_chan.sv | 123 ++++++++++++
 rtl/clkgen_multi.sv | 58 +++++
 tb/tb_clkgen_multi.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and default widths for the multi-channel clock generator.
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } chan_state_e;

  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned BURST_W_DEF = 8;
  localparam int unsigned DIV_RST_DEF = 0;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgen_if.sv
// Configuration/enable and clock-output bundle for clkgen_multi.
interface clkgen_if #(
  parameter int unsigned NUM_CH  = clkgen_pkg::NUM_CH_DEF,
  parameter int unsigned DIV_W   = clkgen_pkg::DIV_W_DEF,
  parameter int unsigned BURST_W = clkgen_pkg::BURST_W_DEF
);
  localparam int unsigned CH_W = clkgen_pkg::ch_width(NUM_CH);

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [DIV_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic [NUM_CH-1:0]  ch_en;
  logic [NUM_CH-1:0]  clk_out;
  logic [NUM_CH-1:0]  tick;
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  done;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_burst, ch_en,
    input  clk_out, tick, busy, done
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_burst, ch_en,
    output clk_out, tick, busy, done
  );

endinterface

// File: rtl/clkgen_chan.sv
// One divided-clock channel: IDLE/RUN/DONE FSM, half-period counter,
// divide/burst shadows and the registered clock/tick outputs.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_i,
  input  logic               wr_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               en_i,
  output logic               clk_o,
  output logic               tick_o,
  output logic               busy_o,
  output logic               done_o
);

  chan_state_e        state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_act_q, div_act_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic [DIV_W-1:0]   div_sh_q, div_sh_d;
  logic [BURST_W-1:0] burst_sh_q, burst_sh_d;

  logic [DIV_W-1:0]   div_nx;
  logic [BURST_W-1:0] burst_nx;
  logic               terminal;

  // A write landing on the same cycle as a load/reload bypasses the shadow.
  assign div_nx   = wr_i ? div_i : div_sh_q;
  assign burst_nx = wr_i ? burst_i : burst_sh_q;
  assign terminal = (cnt_q == div_act_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= DIV_W'(DIV_RST);
      rem_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      div_sh_q   <= DIV_W'(DIV_RST);
      burst_sh_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      rem_q      <= rem_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      div_sh_q   <= div_sh_d;
      burst_sh_q <= burst_sh_d;
    end
  end

  // remaining==0 in RUN means free-run; the last burst toggle leaves it at 0 in DONE.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (!sync_i && terminal && (rem_q == BURST_W'(1))) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    rem_d      = rem_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    div_sh_d   = div_nx;
    burst_sh_d = burst_nx;
    busy_o     = (state_q == RUN);
    done_o     = (state_q == DONE);
    clk_o      = clk_q;
    tick_o     = tick_q;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d     = '0;
          clk_d     = 1'b0;
          div_act_d = div_nx;
          rem_d     = burst_nx;
        end
        RUN: begin
          if (sync_i) begin
            cnt_d     = '0;
            clk_d     = 1'b0;
            div_act_d = div_nx;
            rem_d     = burst_nx;
          end else if (terminal) begin
            cnt_d     = '0;
            clk_d     = ~clk_q;
            tick_d    = 1'b1;
            div_act_d = div_nx;
            if (rem_q != '0) rem_d = rem_q - BURST_W'(1);
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/clkgen_multi.sv
// NUM_CH independent divided clocks from one system clock. Defining
// CLKGEN_SYNC_EN adds a 'sync' input that phase-aligns all running channels.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input logic     clk,
  input logic     rst,
`ifdef CLKGEN_SYNC_EN
  input logic     sync,
`endif
  clkgen_if.slave bus
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic              sync_w;
  logic [NUM_CH-1:0] wr_sel;

`ifdef CLKGEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Select values at or beyond NUM_CH match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clkgen_chan #(
      .DIV_W   (DIV_W),
      .BURST_W (BURST_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sync_i  (sync_w),
      .wr_i    (wr_sel[g]),
      .div_i   (bus.cfg_div),
      .burst_i (bus.cfg_burst),
      .en_i    (bus.ch_en[g]),
      .clk_o   (bus.clk_out[g]),
      .tick_o  (bus.tick[g]),
      .busy_o  (bus.busy[g]),
      .done_o  (bus.done[g])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi (NUM_CH=3) against a count-down
// behavioural model; the sync test is compiled in with CLKGEN_SYNC_EN.
module tb_clkgen_multi;

  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BURST_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sync = 1'b0;

  clkgen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  clkgen_multi #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .BURST_W (BURST_W),
    .DIV_RST (0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef CLKGEN_SYNC_EN
    .sync (sync),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: state 0=idle 1=run 2=done; 'left' = edges until the next toggle,
  // 'togs' = toggles still owed in a burst (0 = unlimited).
  int   m_st[NUM_CH];
  int   m_left[NUM_CH];
  int   m_togs[NUM_CH];
  int   m_sh_div[NUM_CH];
  int   m_sh_burst[NUM_CH];
  logic m_clk[NUM_CH];
  logic m_tick[NUM_CH];
  logic [NUM_CH-1:0] e_clk, e_tick, e_busy, e_done;

  task automatic step();
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      bit wr;
      int ndiv, nb;
      wr   = bus.cfg_we && (int'(bus.cfg_ch) == c);
      ndiv = wr ? int'(bus.cfg_div) : m_sh_div[c];
      nb   = wr ? int'(bus.cfg_burst) : m_sh_burst[c];
      if (rst) begin
        m_st[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        m_sh_div[c] = 0; m_sh_burst[c] = 0;
        continue;
      end
      m_tick[c] = 1'b0;
      if (!bus.ch_en[c]) begin
        m_st[c] = 0; m_clk[c] = 1'b0;
      end else if (m_st[c] == 0) begin
        m_st[c] = 1; m_left[c] = ndiv + 1; m_togs[c] = nb;
      end else if (m_st[c] == 1) begin
        if (sync) begin
          m_left[c] = ndiv + 1; m_togs[c] = nb; m_clk[c] = 1'b0;
        end else begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_clk[c] = ~m_clk[c]; m_tick[c] = 1'b1; m_left[c] = ndiv + 1;
            if (m_togs[c] > 0) begin
              m_togs[c]--;
              if (m_togs[c] == 0) m_st[c] = 2;
            end
          end
        end
      end
      if (wr) begin
        m_sh_div[c] = int'(bus.cfg_div); m_sh_burst[c] = int'(bus.cfg_burst);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c] = m_clk[c]; e_tick[c] = m_tick[c];
      e_busy[c] = (m_st[c] == 1); e_done[c] = (m_st[c] == 2);
    end
    #1;
  endtask

  task automatic cfg_write(input int ch, input int div, input int burst);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch);
    bus.cfg_div = 8'(div); bus.cfg_burst = 8'(burst);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.ch_en = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=000", i, {bus.clk_out, bus.tick, bus.busy, bus.done});
      end
    end
    rst = 1'b0; bus.ch_en = 3'b001;
    step();
    checks++;
    if (bus.busy[0] !== 1'b1) begin
      errors++; $display("FAIL reset_ch0_busy got=%b exp=1", bus.busy[0]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (bus.tick[0] !== 1'b1 || bus.clk_out[0] !== logic'(k % 2 == 0)) begin
        errors++;
        $display("FAIL div0_period k=%0d got tick=%b clk=%b exp tick=1 clk=%b", k, bus.tick[0], bus.clk_out[0], k % 2 == 0);
      end
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== {e_clk, e_tick, e_busy, e_done}) begin
        errors++;
        $display("FAIL div0_model got=%h exp=%h", {bus.clk_out, bus.tick, bus.busy, bus.done}, {e_clk, e_tick, e_busy, e_done});
      end
    end
  endtask

  task automatic run_burst1(input string name);
    int n = 0, togs = 0;
    while (!bus.done[1] && n < 200) begin
      step(); n++;
      if (bus.tick[1]) togs++;
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== {e_clk, e_tick, e_busy, e_done}) begin
        errors++;
        $display("FAIL %s_model n=%0d got=%h exp=%h", name, n, {bus.clk_out, bus.tick, bus.busy, bus.done}, {e_clk, e_tick, e_busy, e_done});
      end
    end
    checks++;
    if (n != 60 || togs != 20 || bus.clk_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL %s_done cycles=%0d toggles=%0d clk=%b exp 60/20/0", name, n, togs, bus.clk_out[1]);
    end
  endtask

  task automatic test_burst();
    bus.ch_en = 3'b000;
    step();
    cfg_write(1, 2, 20);
    bus.ch_en = 3'b010;
    step();
    checks++;
    if (bus.busy[1] !== 1'b1 || bus.done[1] !== 1'b0) begin
      errors++; $display("FAIL burst_start busy=%b done=%b exp 1/0", bus.busy[1], bus.done[1]);
    end
    run_burst1("burst");
  endtask

  task automatic test_en_drop();
    bus.ch_en[1] = 1'b0;
    step();
    checks++;
    if (bus.done[1] !== 1'b0 || bus.busy[1] !== 1'b0) begin
      errors++; $display("FAIL done_clear done=%b busy=%b exp 0/0", bus.done[1], bus.busy[1]);
    end
    bus.ch_en[1] = 1'b1;
    for (int i = 0; i < 34; i++) step();
    checks++;
    if (bus.clk_out[1] !== 1'b1 || bus.busy[1] !== 1'b1) begin
      errors++; $display("FAIL midburst clk=%b busy=%b exp 1/1", bus.clk_out[1], bus.busy[1]);
    end
    bus.ch_en[1] = 1'b0;
    step();
    checks++;
    if (bus.clk_out[1] !== 1'b0 || bus.busy[1] !== 1'b0 || bus.tick[1] !== 1'b0) begin
      errors++; $display("FAIL en_drop clk=%b busy=%b tick=%b exp 0/0/0", bus.clk_out[1], bus.busy[1], bus.tick[1]);
    end
    bus.ch_en[1] = 1'b1;
    step();
    run_burst1("restart");
  endtask

  task automatic test_div_change();
    int q[$];
    int exp_q[6] = '{5, 7, 9, 14, 16, 18};
    cfg_write(2, 4, 0);
    bus.ch_en[2] = 1'b1;
    step();
    for (int e = 1; e < 20; e++) begin
      if (e == 2 || e == 14) begin
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 8'd1; bus.cfg_burst = 8'd0;
      end else if (e == 8) begin
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 8'd4; bus.cfg_burst = 8'd0;
      end
      step();
      bus.cfg_we = 1'b0;
      if (bus.tick[2]) q.push_back(e);
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== {e_clk, e_tick, e_busy, e_done}) begin
        errors++;
        $display("FAIL divchg_model e=%0d got=%h exp=%h", e, {bus.clk_out, bus.tick, bus.busy, bus.done}, {e_clk, e_tick, e_busy, e_done});
      end
    end
    checks++;
    if (q.size() != 6) begin
      errors++; $display("FAIL divchg_count got=%0d exp=6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q[i] != exp_q[i]) begin
          errors++; $display("FAIL divchg_edge idx=%0d got=%0d exp=%0d", i, q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_ch();
    bus.ch_en[0] = 1'b0;
    step();
    cfg_write(3, 7, 1);
    bus.ch_en[0] = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.tick[0] !== 1'b1 || bus.busy[0] !== 1'b1) begin
        errors++; $display("FAIL bad_ch i=%0d tick=%b busy=%b exp 1/1", i, bus.tick[0], bus.busy[0]);
      end
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== {e_clk, e_tick, e_busy, e_done}) begin
        errors++;
        $display("FAIL bad_ch_model got=%h exp=%h", {bus.clk_out, bus.tick, bus.busy, bus.done}, {e_clk, e_tick, e_busy, e_done});
      end
    end
  endtask

`ifdef CLKGEN_SYNC_EN
  task automatic test_sync();
    bus.ch_en = 3'b000;
    step();
    cfg_write(0, 1, 0);
    cfg_write(1, 3, 0);
    bus.ch_en = 3'b011;
    step();
    for (int i = 0; i < int'($urandom_range(3, 9)); i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (bus.clk_out[1:0] !== 2'b00 || bus.tick[1:0] !== 2'b00) begin
      errors++; $display("FAIL sync_align clk=%b tick=%b exp 00/00", bus.clk_out[1:0], bus.tick[1:0]);
    end
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (bus.tick[0] !== logic'(e % 2 == 0) || bus.tick[1] !== logic'(e == 4)) begin
        errors++; $display("FAIL sync_phase e=%0d tick=%b exp=%b%b", e, bus.tick[1:0], e == 4, e % 2 == 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_ch = 2'($urandom_range(0, 3));
      bus.cfg_div = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      bus.cfg_burst = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) bus.ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
`ifdef CLKGEN_SYNC_EN
      sync = ($urandom_range(0, 39) == 0);
`endif
      step();
      checks++;
      if ({bus.clk_out, bus.tick, bus.busy, bus.done} !== {e_clk, e_tick, e_busy, e_done}) begin
        errors++;
        $display("FAIL random_model i=%0d got=%h exp=%h", i, {bus.clk_out, bus.tick, bus.busy, bus.done}, {e_clk, e_tick, e_busy, e_done});
      end
    end
    rst = 1'b0; sync = 1'b0; bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_burst = '0; bus.ch_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = 0; m_left[c] = 0; m_togs[c] = 0; m_sh_div[c] = 0; m_sh_burst[c] = 0;
      m_clk[c] = 1'b0; m_tick[c] = 1'b0;
    end
    test_reset();
    test_burst();
    test_en_drop();
    test_div_change();
    test_bad_ch();
`ifdef CLKGEN_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
